serial_accum: RTL and testbench

SERIAL_ACCUM -- requirements
Module: serial_accum

---
 rtl/serial_accum_pkg.sv | 16 +
 rtl/serial_accum_if.sv | 32 +++
 rtl/serial_accum_add.sv | 40 ++++
 rtl/serial_accum.sv | 127 ++++++++++++
 tb/tb_serial_accum.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_accum_pkg.sv
// Shared types and parameter defaults for the serial frame accumulator.
package serial_accum_pkg;

    localparam int DATA_W_DEF   = 8;
    localparam int CNT_W_DEF    = 8;
    localparam int SUM_W_DEF    = 16;
    localparam int SIGNED_DEF   = 1;
    localparam int SATURATE_DEF = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_e;

endpackage

// File: rtl/serial_accum_if.sv
// Frame-control, sample-input and result handshake signals of the accumulator.
// Signal suffixes are from the accumulator's point of view.
interface serial_accum_if
    import serial_accum_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int SUM_W  = SUM_W_DEF
) ();

    logic              start_i;
    logic [CNT_W-1:0]  n_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [DATA_W-1:0] data_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [SUM_W-1:0]  sum_o;
    logic              ovf_o;
    logic              busy_o;

    modport slave (
        input  start_i, n_i, in_valid_i, data_i, out_ready_i,
        output in_ready_o, out_valid_o, sum_o, ovf_o, busy_o
    );

    modport master (
        output start_i, n_i, in_valid_i, data_i, out_ready_i,
        input  in_ready_o, out_valid_o, sum_o, ovf_o, busy_o
    );

endinterface

// File: rtl/serial_accum_add.sv
// Combinational extend-and-add with overflow detect and optional clamping.
// The add is done one bit wider than SUM_W so the true sum is always visible;
// SUM_W must be at least DATA_W + 1.
module serial_accum_add
    import serial_accum_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SUM_W    = SUM_W_DEF,
    parameter int SIGNED   = SIGNED_DEF,
    parameter int SATURATE = SATURATE_DEF
) (
    input  logic [SUM_W-1:0]  acc_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [SUM_W-1:0]  sum_o,
    output logic              ovf_o
);

    logic [SUM_W:0]   acc_x;
    logic [SUM_W:0]   data_x;
    logic [SUM_W:0]   true_sum;
    logic [SUM_W-1:0] clamp;

    // Extend both operands, add, flag out-of-range results and pick the clamp value.
    always_comb begin
        acc_x    = {((SIGNED != 0) ? acc_i[SUM_W-1] : 1'b0), acc_i};
        data_x   = {{(SUM_W + 1 - DATA_W){((SIGNED != 0) ? data_i[DATA_W-1] : 1'b0)}}, data_i};
        true_sum = acc_x + data_x;
        if (SIGNED != 0) begin
            ovf_o = true_sum[SUM_W] ^ true_sum[SUM_W-1];
            // Sign of the true sum tells which rail was crossed.
            clamp = true_sum[SUM_W] ? {1'b1, {(SUM_W-1){1'b0}}} : {1'b0, {(SUM_W-1){1'b1}}};
        end else begin
            // Operands are non-negative, so only the top rail can be crossed.
            ovf_o = true_sum[SUM_W];
            clamp = '1;
        end
        sum_o = ((SATURATE != 0) && ovf_o) ? clamp : true_sum[SUM_W-1:0];
    end

endmodule

// File: rtl/serial_accum.sv
// Frame accumulator: sums n_i samples accepted over a valid/ready stream and
// presents the total (plus a sticky overflow flag) on a valid/ready result port.
//
//   state | meaning
//   IDLE  | no frame; waiting for start_i
//   ACC   | accepting samples, cnt_q samples still to go
//   HOLD  | result valid on sum_o/ovf_o until out_ready_i
module serial_accum
    import serial_accum_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int SUM_W    = SUM_W_DEF,
    parameter int SIGNED   = SIGNED_DEF,
    parameter int SATURATE = SATURATE_DEF
) (
    input  logic          clk_i,
    input  logic          rst_i,
    serial_accum_if.slave sa_if
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SUM_W-1:0] acc_q, acc_d;
    logic             facc_ovf_q, facc_ovf_d;
    logic [SUM_W-1:0] sum_q, sum_d;
    logic             ovf_q, ovf_d;

    logic [SUM_W-1:0] add_sum;
    logic             add_ovf;
    logic             start_acc;
    logic             xfer;

    serial_accum_add #(
        .DATA_W   (DATA_W),
        .SUM_W    (SUM_W),
        .SIGNED   (SIGNED),
        .SATURATE (SATURATE)
    ) u_add (
        .acc_i  (acc_q),
        .data_i (sa_if.data_i),
        .sum_o  (add_sum),
        .ovf_o  (add_ovf)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers: frame counter, running sum, frame overflow, result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            acc_q      <= '0;
            facc_ovf_q <= 1'b0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            facc_ovf_q <= facc_ovf_d;
            sum_q      <= sum_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state and datapath update; a start accepted from HOLD overrides the return to IDLE.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        facc_ovf_d = facc_ovf_q;
        sum_d      = sum_q;
        ovf_d      = ovf_q;

        start_acc = sa_if.start_i &&
                    ((state_q == IDLE) || ((state_q == HOLD) && sa_if.out_ready_i));
        xfer      = (state_q == ACC) && sa_if.in_valid_i;

        case (state_q)
            IDLE: ;
            ACC: begin
                if (xfer) begin
                    acc_d      = add_sum;
                    facc_ovf_d = facc_ovf_q | add_ovf;
                    cnt_d      = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = HOLD;
                        sum_d   = add_sum;
                        ovf_d   = facc_ovf_q | add_ovf;
                    end
                end
            end
            HOLD: begin
                if (sa_if.out_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (start_acc) begin
            if (sa_if.n_i == '0) begin
                state_d = HOLD;
                sum_d   = '0;
                ovf_d   = 1'b0;
            end else begin
                state_d    = ACC;
                cnt_d      = sa_if.n_i;
                acc_d      = '0;
                facc_ovf_d = 1'b0;
            end
        end
    end

    assign sa_if.in_ready_o  = (state_q == ACC);
    assign sa_if.out_valid_o = (state_q == HOLD);
    assign sa_if.busy_o      = (state_q != IDLE);
    assign sa_if.sum_o       = sum_q;
    assign sa_if.ovf_o       = ovf_q;

endmodule

// File: tb/tb_serial_accum.sv
// Directed bench for serial_accum. Four instances share one stimulus stream:
// defaults, SUM_W=9 wrapping, SUM_W=9 saturating, and unsigned samples.
module tb_serial_accum;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] n;
    logic       in_valid;
    logic [7:0] data;
    logic       out_ready;

    int n_tests;
    int n_fail;

    serial_accum_if #(.DATA_W(8), .CNT_W(8), .SUM_W(16)) if_def ();
    serial_accum_if #(.DATA_W(8), .CNT_W(8), .SUM_W(9))  if_ws ();
    serial_accum_if #(.DATA_W(8), .CNT_W(8), .SUM_W(9))  if_wt ();
    serial_accum_if #(.DATA_W(8), .CNT_W(8), .SUM_W(16)) if_un ();

    assign if_def.start_i = start;  assign if_def.n_i = n;  assign if_def.in_valid_i = in_valid;
    assign if_def.data_i  = data;   assign if_def.out_ready_i = out_ready;
    assign if_ws.start_i  = start;  assign if_ws.n_i  = n;  assign if_ws.in_valid_i  = in_valid;
    assign if_ws.data_i   = data;   assign if_ws.out_ready_i  = out_ready;
    assign if_wt.start_i  = start;  assign if_wt.n_i  = n;  assign if_wt.in_valid_i  = in_valid;
    assign if_wt.data_i   = data;   assign if_wt.out_ready_i  = out_ready;
    assign if_un.start_i  = start;  assign if_un.n_i  = n;  assign if_un.in_valid_i  = in_valid;
    assign if_un.data_i   = data;   assign if_un.out_ready_i  = out_ready;

    serial_accum u_def (.clk_i(clk), .rst_i(rst), .sa_if(if_def.slave));
    serial_accum #(.SUM_W(9), .SIGNED(1), .SATURATE(0)) u_ws (.clk_i(clk), .rst_i(rst), .sa_if(if_ws.slave));
    serial_accum #(.SUM_W(9), .SIGNED(1), .SATURATE(1)) u_wt (.clk_i(clk), .rst_i(rst), .sa_if(if_wt.slave));
    serial_accum #(.SIGNED(0)) u_un (.clk_i(clk), .rst_i(rst), .sa_if(if_un.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input logic [7:0] len);
        start = 1'b1;
        n     = len;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input logic [7:0] d);
        in_valid = 1'b1;
        data     = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        rst       = 1'b1;
        start     = 1'b0;
        n         = 8'd0;
        in_valid  = 1'b0;
        data      = 8'd0;
        out_ready = 1'b0;

        // Reset with start/valid/ready all asserted: reset must win.
        tick();
        start = 1'b1; n = 8'd3; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        check("rst_busy",      32'(if_def.busy_o),      32'd0);
        check("rst_in_ready",  32'(if_def.in_ready_o),  32'd0);
        check("rst_out_valid", 32'(if_def.out_valid_o), 32'd0);
        check("rst_sum",       32'(if_def.sum_o),       32'd0);
        check("rst_ovf",       32'(if_def.ovf_o),       32'd0);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rst = 1'b0;
        tick();

        // n=4: 5, -3, 10, 1 back-to-back.
        start_frame(8'd4);
        check("f1_in_ready", 32'(if_def.in_ready_o), 32'd1);
        check("f1_busy",     32'(if_def.busy_o),     32'd1);
        feed(8'd5);
        feed(8'hFD);
        feed(8'd10);
        check("f1_valid_early", 32'(if_def.out_valid_o), 32'd0);
        feed(8'd1);
        check("f1_valid", 32'(if_def.out_valid_o), 32'd1);
        check("f1_sum",   32'(if_def.sum_o),       32'd13);
        check("f1_ovf",   32'(if_def.ovf_o),       32'd0);
        check("f1_in_ready_hold", 32'(if_def.in_ready_o), 32'd0);
        release_out();
        check("f1_idle_busy",  32'(if_def.busy_o),      32'd0);
        check("f1_idle_valid", 32'(if_def.out_valid_o), 32'd0);
        check("f1_idle_sum",   32'(if_def.sum_o),       32'd13);

        // n=3: 7, two idle cycles, 8, 9; result held for 5 cycles.
        start_frame(8'd3);
        feed(8'd7);
        tick();
        tick();
        check("f2_gap_ready", 32'(if_def.in_ready_o),  32'd1);
        check("f2_gap_valid", 32'(if_def.out_valid_o), 32'd0);
        feed(8'd8);
        feed(8'd9);
        check("f2_valid", 32'(if_def.out_valid_o), 32'd1);
        check("f2_sum",   32'(if_def.sum_o),       32'd24);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("f2_hold_sum",   32'(if_def.sum_o),       32'd24);
            check("f2_hold_valid", 32'(if_def.out_valid_o), 32'd1);
        end
        release_out();
        check("f2_idle_busy", 32'(if_def.busy_o), 32'd0);

        // Empty frame, then restart straight from HOLD.
        start_frame(8'd0);
        check("f3_valid",    32'(if_def.out_valid_o), 32'd1);
        check("f3_sum",      32'(if_def.sum_o),       32'd0);
        check("f3_ovf",      32'(if_def.ovf_o),       32'd0);
        check("f3_in_ready", 32'(if_def.in_ready_o),  32'd0);
        in_valid = 1'b1; data = 8'd99;
        tick();
        in_valid = 1'b0;
        check("f3_still_hold", 32'(if_def.out_valid_o), 32'd1);
        check("f3_ready_low",  32'(if_def.in_ready_o),  32'd0);
        out_ready = 1'b1; start = 1'b1; n = 8'd2;
        tick();
        out_ready = 1'b0; start = 1'b0;
        check("f4_in_ready", 32'(if_def.in_ready_o),  32'd1);
        check("f4_valid",    32'(if_def.out_valid_o), 32'd0);
        // start during ACC is ignored; frame still ends after 2 samples.
        start = 1'b1; n = 8'd7;
        feed(8'd20);
        start = 1'b0;
        feed(8'd30);
        check("f4_done", 32'(if_def.out_valid_o), 32'd1);
        check("f4_sum",  32'(if_def.sum_o),       32'd50);
        release_out();

        // 127 x3 into 9-bit signed: wraps to 0x17D, saturates at 255.
        start_frame(8'd3);
        feed(8'd127);
        feed(8'd127);
        feed(8'd127);
        check("f5_wrap_sum", 32'(if_ws.sum_o), 32'h17D);
        check("f5_wrap_ovf", 32'(if_ws.ovf_o), 32'd1);
        check("f5_sat_sum",  32'(if_wt.sum_o), 32'd255);
        check("f5_sat_ovf",  32'(if_wt.ovf_o), 32'd1);
        check("f5_def_sum",  32'(if_def.sum_o), 32'd381);
        check("f5_def_ovf",  32'(if_def.ovf_o), 32'd0);
        release_out();

        // 127,127,127,-128: clamp then come back in range; overflow stays sticky.
        start_frame(8'd4);
        feed(8'd127);
        feed(8'd127);
        feed(8'd127);
        feed(8'h80);
        check("f6_sat_sum",  32'(if_wt.sum_o), 32'd127);
        check("f6_sat_ovf",  32'(if_wt.ovf_o), 32'd1);
        check("f6_wrap_sum", 32'(if_ws.sum_o), 32'h0FD);
        check("f6_wrap_ovf", 32'(if_ws.ovf_o), 32'd1);
        check("f6_def_sum",  32'(if_def.sum_o), 32'd253);
        check("f6_un_sum",   32'(if_un.sum_o),  32'd509);
        release_out();

        // 0xFF x2: unsigned 510, signed -2.
        start_frame(8'd2);
        feed(8'hFF);
        feed(8'hFF);
        check("f7_un_sum",  32'(if_un.sum_o),  32'd510);
        check("f7_un_ovf",  32'(if_un.ovf_o),  32'd0);
        check("f7_def_sum", 32'(if_def.sum_o), 32'hFFFE);
        release_out();

        // Reset one sample into a 5-sample frame: frame discarded.
        start_frame(8'd5);
        feed(8'hFF);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("f8_busy",  32'(if_un.busy_o),     32'd0);
        check("f8_valid", 32'(if_un.out_valid_o), 32'd0);
        check("f8_sum",   32'(if_un.sum_o),      32'd0);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1; data = 8'd1;
            tick();
            check("f8_no_result", 32'(if_un.out_valid_o), 32'd0);
        end
        in_valid = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
